// File: rtl/lut_mac_pkg.sv
//------------------------------------------------------------------------------
// lut_mac_pkg
//
// Purpose : Shared definitions for the LUT multiplier MAC datapath.
//           Holds the accumulator FSM state encoding and the default widths
//           used by lut_product_accumulator and its sub-modules.
// Ports   : none (package)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package lut_mac_pkg;

   // Accumulator FSM states. ACCUM takes products; DONE holds the result.
   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } lut_mac_state_e;

   // Default widths for the N=4 LUT multiplier feeding this stage.
   localparam int unsigned LUT_PROD_W    = 8;   // N+4 product width
   localparam int unsigned LUT_ACC_W     = 12;  // accumulator / result width
   localparam int unsigned LUT_MAX_TERMS = 8;   // products per burst ceiling
   localparam int unsigned LUT_CNT_W     = 4;   // term counter width

   // Smallest counter width able to represent the value max_terms.
   function automatic int unsigned cnt_width(input int unsigned max_terms);
      return $clog2(max_terms + 1);
   endfunction

endpackage : lut_mac_pkg

// File: rtl/lut_product_accumulator_if.sv
//------------------------------------------------------------------------------
// lut_product_accumulator_if
//
// Purpose : Groups the product input stream and the result output stream of
//           lut_product_accumulator into one bundle.
// Signals :
//   in_valid   product on in_prod is valid              (master -> slave)
//   in_ready   accumulator can accept a product         (slave  -> master)
//   in_prod    unsigned product, PROD_W bits            (master -> slave)
//   in_last    product closes the burst                 (master -> slave)
//   out_valid  out_sum/out_count/out_ovf valid          (slave  -> master)
//   out_ready  consumer takes the result                (master -> slave)
//   out_sum    accumulated sum, ACC_W bits              (slave  -> master)
//   out_count  products in the burst, CNT_W bits        (slave  -> master)
//   out_ovf    sum exceeded 2^ACC_W-1 during the burst  (slave  -> master)
// Modports: master = producer/consumer side, slave = accumulator side.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface lut_product_accumulator_if #(
   parameter int unsigned PROD_W = 8,
   parameter int unsigned ACC_W  = 12,
   parameter int unsigned CNT_W  = 4
);

   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport master (
      output in_valid,
      output in_prod,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_count,
      input  out_ovf
   );

   modport slave (
      input  in_valid,
      input  in_prod,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_count,
      output out_ovf
   );

endinterface : lut_product_accumulator_if

// File: rtl/lut_acc_adder.sv
//------------------------------------------------------------------------------
// lut_acc_adder
//
// Purpose : Adds a zero-extended product to the accumulator at ACC_W+1 bits
//           and reports the carry out of ACC_W. Optionally clamps the result.
// Config  : LUT_ACC_SATURATE_EN
//             defined   - on carry the sum clamps to 2^ACC_W-1
//             undefined - the sum wraps modulo 2^ACC_W
// Ports   :
//   acc    in   ACC_W   current accumulator value
//   prod   in   PROD_W  unsigned product to add
//   sum    out  ACC_W   next accumulator value (wrapped or clamped)
//   carry  out  1       carry out of bit ACC_W-1 (overflow indication)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module lut_acc_adder #(
   parameter int unsigned PROD_W = 8,
   parameter int unsigned ACC_W  = 12
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] prod_ext;
   logic [ACC_W:0] sum_wide;

   assign prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
   assign sum_wide = {1'b0, acc} + prod_ext;
   assign carry    = sum_wide[ACC_W];

`ifdef LUT_ACC_SATURATE_EN
   // Once clamped at all-ones, any non-zero product carries again and any
   // zero product leaves the value alone, so the clamp persists for the
   // rest of the burst without extra state.
   assign sum = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
   assign sum = sum_wide[ACC_W-1:0];
`endif

endmodule : lut_acc_adder

// File: rtl/lut_product_accumulator.sv
//------------------------------------------------------------------------------
// lut_product_accumulator
//
// Purpose : Downstream stage of the 4-bit LUT multiplier. Accepts products on
//           a valid/ready stream, sums a burst of them into a wider register
//           and presents the result (sum, term count, overflow flag) on a
//           held valid/ready output. A burst closes on in_last or when
//           MAX_TERMS products have been taken.
// Config  : LUT_ACC_SATURATE_EN (see lut_acc_adder) selects clamp vs wrap.
// Ports   :
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous, active-high reset
//   bus    slave modport of lut_product_accumulator_if
//                  (in_valid/in_ready/in_prod/in_last,
//                   out_valid/out_ready/out_sum/out_count/out_ovf)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module lut_product_accumulator
   import lut_mac_pkg::*;
#(
   parameter int unsigned PROD_W    = LUT_PROD_W,
   parameter int unsigned ACC_W     = LUT_ACC_W,
   parameter int unsigned MAX_TERMS = LUT_MAX_TERMS,
   parameter int unsigned CNT_W     = LUT_CNT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   lut_product_accumulator_if.slave   bus
);

   // Counter value on which the next transfer is the MAX_TERMS-th product.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

   lut_mac_state_e    state_q;
   lut_mac_state_e    state_d;

   logic [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ovf_q;

   logic [ACC_W-1:0]  out_sum_q;
   logic [CNT_W-1:0]  out_count_q;
   logic              out_ovf_q;

   logic [ACC_W-1:0]  add_sum;
   logic              add_carry;
   logic [CNT_W-1:0]  cnt_inc;

   logic              transfer;
   logic              close_burst;
   logic              release_result;

   //---------------------------------------------------------------------------
   // Datapath: accumulator adder (wrap or clamp chosen inside the adder)
   //---------------------------------------------------------------------------
   lut_acc_adder #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_adder (
      .acc   (acc_q),
      .prod  (bus.in_prod),
      .sum   (add_sum),
      .carry (add_carry)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);

   //---------------------------------------------------------------------------
   // FSM next-state and handshake decode
   //---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      transfer       = 1'b0;
      close_burst    = 1'b0;
      release_result = 1'b0;

      case (state_q)
         ACCUM: begin
            // in_ready is 1 throughout ACCUM, so a valid product is a transfer.
            transfer    = bus.in_valid;
            close_burst = transfer & (bus.in_last | (cnt_q == LAST_CNT));
            if (close_burst) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Products offered here are not taken; only the consumer matters.
            if (bus.out_ready) begin
               release_result = 1'b1;
               state_d        = ACCUM;
            end
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // State, accumulator and result registers
   //---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;

         if (release_result) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else if (transfer) begin
            acc_q <= add_sum;
            cnt_q <= cnt_inc;
            ovf_q <= ovf_q | add_carry;
         end

         // The closing transfer loads the post-add values directly so the
         // result is visible one cycle after that transfer.
         if (close_burst) begin
            out_sum_q   <= add_sum;
            out_count_q <= cnt_inc;
            out_ovf_q   <= ovf_q | add_carry;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_sum   = out_sum_q;
   assign bus.out_count = out_count_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule : lut_product_accumulator
